// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU mul/div/sqrt issue stage: op codes, FSM states,
// canonical NaN, exception flag layout and the unpacked-operand record.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Flag vector layout is {NV, DZ, OF, UF, NX}.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [4:0] FLAGS_NV_ONLY = 5'(1 << FLAG_NV);

  // Fields handed to the engine for one operand.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } operand_t;

  typedef struct packed {
    operand_t f;
    logic     is_snan;
  } unpacked_t;

endpackage

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 single-precision unpacker: sign, exponent, significand
// with hidden bit, and zero/inf/NaN/signaling-NaN classification.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] operand,
  output unpacked_t   fields
);

  logic [7:0]  exp;
  logic [22:0] frac;

  assign exp  = operand[30:23];
  assign frac = operand[22:0];

  assign fields.f.sign    = operand[31];
  assign fields.f.exp     = exp;
  assign fields.f.sig     = {exp != 8'h00, frac};
  assign fields.f.is_zero = (exp == 8'h00) && (frac == 23'd0);
  assign fields.f.is_inf  = (exp == 8'hFF) && (frac == 23'd0);
  assign fields.f.is_nan  = (exp == 8'hFF) && (frac != 23'd0);
  // A NaN is signaling when the quiet bit (MSB of the fraction) is clear.
  assign fields.is_snan   = (exp == 8'hFF) && (frac != 23'd0) && !frac[22];

endmodule

// File: rtl/fpu_mds_issue.sv
// Issue/response sequencer between the core and a multi-cycle mul/div/sqrt engine,
// with operand unpacking, a WAIT watchdog and sticky accrued exception flags.
module fpu_mds_issue
  import fpu_pkg::*;
#(
  parameter int WD_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        mds_start,
  output logic [1:0]  mds_op,
  output logic [2:0]  mds_rm,
  output logic        sign_A,
  output logic        sign_B,
  output logic [7:0]  exp_A,
  output logic [7:0]  exp_B,
  output logic [23:0] sig_A,
  output logic [23:0] sig_B,
  output logic        isZeroA,
  output logic        isZeroB,
  output logic        isInfA,
  output logic        isInfB,
  output logic        isNaNA,
  output logic        isNaNB,
  output logic        isSignaling,
  output logic        subnormal_sqrt_in,
  input  logic [31:0] mds_out,
  input  logic        mds_done,
  input  logic        overflow,
  input  logic        underflow,
  input  logic        invalid,
  input  logic        inexact,
  input  logic        div_by_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(WD_LIMIT + 1);

  state_e           state;
  unpacked_t        up_a, up_b;
  operand_t         cap_a, cap_b;
  logic             cap_snan, cap_sub_sqrt;
  logic [CNT_W-1:0] wd_cnt;
  logic             req_is_sqrt, rsp_fire;

  fpu_unpack u_unpack_a (.operand(req_a), .fields(up_a));
  fpu_unpack u_unpack_b (.operand(req_b), .fields(up_b));

  assign req_is_sqrt = (req_op == OP_SQRT);
  assign rsp_fire    = rsp_valid && rsp_ready;
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);

  // NOTE: every state register uses non-blocking assignment so all of them update
  // together from pre-edge values; the async reset clears captures and results too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mds_start    <= 1'b0;
      mds_op       <= '0;
      mds_rm       <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_snan     <= 1'b0;
      cap_sub_sqrt <= 1'b0;
      wd_cnt       <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      timeout_err  <= 1'b0;
      fflags       <= '0;
    end else begin
      mds_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          mds_op       <= req_op;
          mds_rm       <= req_rm;
          cap_a        <= up_a.f;
          cap_b        <= req_is_sqrt ? '0 : up_b.f;
          cap_snan     <= up_a.is_snan || (!req_is_sqrt && up_b.is_snan);
          cap_sub_sqrt <= req_is_sqrt && (up_a.f.exp == 8'h00) && !up_a.f.is_zero;
          if (req_op == OP_RSVD) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= CANON_NAN;
            rsp_flags  <= FLAGS_NV_ONLY;
          end else begin
            state     <= START;
            mds_start <= 1'b1;
          end
        end
        START: begin
          state  <= WAIT;
          wd_cnt <= '0;
        end
        WAIT: begin
          if (mds_done) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= mds_out;
            rsp_flags  <= {invalid, div_by_zero, overflow, underflow, inexact};
          end else if (wd_cnt == CNT_W'(WD_LIMIT - 1)) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_result  <= CANON_NAN;
            rsp_flags   <= FLAGS_NV_ONLY;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A clear coinciding with a handshake keeps only the new response's flags.
      if (fflags_clr)    fflags <= rsp_fire ? rsp_flags : '0;
      else if (rsp_fire) fflags <= fflags | rsp_flags;
    end
  end

  assign sign_A            = cap_a.sign;
  assign exp_A             = cap_a.exp;
  assign sig_A             = cap_a.sig;
  assign isZeroA           = cap_a.is_zero;
  assign isInfA            = cap_a.is_inf;
  assign isNaNA            = cap_a.is_nan;
  assign sign_B            = cap_b.sign;
  assign exp_B             = cap_b.exp;
  assign sig_B             = cap_b.sig;
  assign isZeroB           = cap_b.is_zero;
  assign isInfB            = cap_b.is_inf;
  assign isNaNB            = cap_b.is_nan;
  assign isSignaling       = cap_snan;
  assign subnormal_sqrt_in = cap_sub_sqrt;

endmodule

// File: tb/tb_fpu_mds_issue.sv
// Self-checking bench for fpu_mds_issue: directed scenarios plus randomized traffic
// checked against an arithmetic model of unpacking, responses and sticky flags.
module tb_fpu_mds_issue;

  localparam int WD = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_a, req_b;
  logic        mds_start;
  logic [1:0]  mds_op;
  logic [2:0]  mds_rm;
  logic        sign_A, sign_B;
  logic [7:0]  exp_A, exp_B;
  logic [23:0] sig_A, sig_B;
  logic        isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB, isSignaling, subnormal_sqrt_in;
  logic [31:0] mds_out;
  logic        mds_done, overflow, underflow, invalid, inexact, div_by_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags, fflags;
  logic        fflags_clr, busy, timeout_err;

  always #5 clk = ~clk;

  fpu_mds_issue #(.WD_LIMIT(WD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b),
    .mds_start(mds_start), .mds_op(mds_op), .mds_rm(mds_rm),
    .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B), .sig_A(sig_A), .sig_B(sig_B),
    .isZeroA(isZeroA), .isZeroB(isZeroB), .isInfA(isInfA), .isInfB(isInfB),
    .isNaNA(isNaNA), .isNaNB(isNaNB), .isSignaling(isSignaling), .subnormal_sqrt_in(subnormal_sqrt_in),
    .mds_out(mds_out), .mds_done(mds_done), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .inexact(inexact), .div_by_zero(div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int tmo_cnt   = 0;
  logic [4:0] exp_fflags = '0;

  logic [78:0]  dut_fields;
  logic [124:0] dut_all;
  assign dut_fields = {mds_op, mds_rm, sign_A, exp_A, sig_A, sign_B, exp_B, sig_B,
                       isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB, isSignaling, subnormal_sqrt_in};
  assign dut_all = {mds_start, dut_fields, rsp_valid, rsp_result, rsp_flags, fflags, busy, timeout_err};

  always @(negedge clk) begin
    if (mds_start)   start_cnt++;
    if (timeout_err) tmo_cnt++;
  end

  // Reference unpacking from magnitude comparisons on the raw encoding.
  function automatic logic [78:0] model_fields(input logic [1:0] op, input logic [2:0] rm,
                                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    logic [23:0] sa, sb;
    logic za, zb, ia, ib, na, nb, snan, sub, sq;
    sq = (op == 2'd2);
    ma = a & 32'h7FFF_FFFF;
    mb = b & 32'h7FFF_FFFF;
    sa = (ma >= 32'h0080_0000) ? 24'(a[22:0]) + 24'h80_0000 : 24'(a[22:0]);
    sb = (mb >= 32'h0080_0000) ? 24'(b[22:0]) + 24'h80_0000 : 24'(b[22:0]);
    za = (ma == 0);  zb = (mb == 0);
    ia = (ma == 32'h7F80_0000); ib = (mb == 32'h7F80_0000);
    na = (ma > 32'h7F80_0000);  nb = (mb > 32'h7F80_0000);
    snan = (na && ma < 32'h7FC0_0000) || (!sq && nb && mb < 32'h7FC0_0000);
    sub  = sq && ma != 0 && ma < 32'h0080_0000;
    if (sq) begin
      return {op, rm, a[31], a[30:23], sa, 33'd0, za, 1'b0, ia, 1'b0, na, 1'b0, snan, sub};
    end
    return {op, rm, a[31], a[30:23], sa, b[31], b[30:23], sb, za, zb, ia, ib, na, nb, snan, sub};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] s;
    s = {$urandom_range(0, 1), 31'd0};
    case ($urandom_range(0, 7))
      0: return s;
      1: return s | 32'h7F80_0000;
      2: return s | 32'h7FC0_0000 | $urandom_range(0, 32'h3F_FFFF);
      3: return s | 32'h7F80_0000 | $urandom_range(1, 32'h3F_FFFF);
      4: return s | $urandom_range(1, 32'h7F_FFFF);
      default: return $urandom;
    endcase
  endfunction

  // One full transaction: issue, optional engine completion after lat WAIT cycles,
  // response held for hold cycles, then handshake (with optional flag clear).
  task automatic run_op(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eout,
                        input logic [4:0] eflags, input int hold, input logic clr, input string tag);
    logic [78:0] ef;
    logic [31:0] xr;
    logic [4:0]  xf;
    int s0;
    ef = model_fields(op, rm, a, b);
    xr = (op == 2'd3) ? QNAN : eout;
    xf = (op == 2'd3) ? 5'b10000 : eflags;
    s0 = start_cnt;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_idle got %b expected 1", tag, req_ready); end
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_rm = 3'($urandom); req_a = $urandom; req_b = $urandom;
    if (op != 2'd3) begin
      n_checks++;
      if (mds_start !== 1'b1 || dut_fields !== ef) begin
        n_fail++; $display("FAIL %s start got start=%b f=%h expected start=1 f=%h", tag, mds_start, dut_fields, ef);
      end
      @(negedge clk);
      for (int i = 0; i < lat; i++) begin
        n_checks++;
        if (mds_start !== 1'b0 || rsp_valid !== 1'b0 || dut_fields !== ef) begin
          n_fail++; $display("FAIL %s wait_hold got start=%b v=%b f=%h expected 0 0 %h", tag, mds_start, rsp_valid, dut_fields, ef);
        end
        @(negedge clk);
      end
      mds_done = 1'b1; mds_out = eout;
      {invalid, div_by_zero, overflow, underflow, inexact} = eflags;
      @(negedge clk);
      mds_done = 1'b0; mds_out = $urandom;
      {invalid, div_by_zero, overflow, underflow, inexact} = 5'($urandom);
    end else begin
      n_checks++;
      if (mds_start !== 1'b0) begin n_fail++; $display("FAIL %s rsvd_start got %b expected 0", tag, mds_start); end
    end
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== xr || rsp_flags !== xf || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s rsp got v=%b r=%h f=%b expected v=1 r=%h f=%b", tag, rsp_valid, rsp_result, rsp_flags, xr, xf);
      end
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1; fflags_clr = clr; req_valid = 1'b1; req_op = 2'd3;
    @(negedge clk);
    rsp_ready = 1'b0; fflags_clr = 1'b0; req_valid = 1'b0;
    exp_fflags = clr ? xf : (exp_fflags | xf);
    n_checks++;
    if (fflags !== exp_fflags || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s accept got ff=%b v=%b busy=%b expected ff=%b v=0 busy=0", tag, fflags, rsp_valid, busy, exp_fflags);
    end
    n_checks++;
    if (start_cnt - s0 !== ((op != 2'd3) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s start_count got %0d expected %0d", tag, start_cnt - s0, (op != 2'd3) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (dut_all !== '0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state got %h ready=%b expected 0 ready=1", dut_all, req_ready);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'd0, 3'd0, 32'h4000_0000, 32'h4040_0000, 3, 32'h40C0_0000, 5'b00000, 0, 1'b0, "mul_2x3");
    run_op(2'd2, 3'd1, 32'h0000_0001, 32'hC123_4567, 2, 32'h1A00_0000, 5'b00000, 1, 1'b0, "sqrt_subn");
    run_op(2'd1, 3'd2, 32'h3F80_0000, 32'h7F80_0001, 4, QNAN, 5'b10000, 0, 1'b0, "div_snan");
    run_op(2'd3, 3'd3, 32'h1234_5678, 32'h8765_4321, 0, 32'h0, 5'b0, 0, 1'b0, "reserved");
  endtask

  task automatic test_timeout();
    int n, t0;
    t0 = tmo_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_rm = 3'd0; req_a = 32'h3F80_0000; req_b = 32'h3F80_0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    n_checks++;
    if (n !== WD || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_latency got %0d cycles tmo=%b expected %0d tmo=1", n, timeout_err, WD);
    end
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      mds_done = (h == 1); mds_out = 32'hDEAD_BEEF; inexact = 1'b1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== QNAN || rsp_flags !== 5'b10000 || timeout_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_hold got v=%b r=%h f=%b tmo=%b expected 1 %h 10000 0", rsp_valid, rsp_result, rsp_flags, timeout_err, QNAN);
      end
    end
    mds_done = 1'b0; inexact = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_fflags = exp_fflags | 5'b10000;
    n_checks++;
    if (fflags !== exp_fflags || tmo_cnt - t0 !== 1) begin
      n_fail++; $display("FAIL timeout_accept got ff=%b pulses=%0d expected ff=%b pulses=1", fflags, tmo_cnt - t0, exp_fflags);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_rm = 3'd4; req_a = 32'h4120_0000; req_b = 32'h4000_0000;
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_all !== '0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid got %h ready=%b expected 0 ready=1", dut_all, req_ready);
    end
    @(negedge clk);
    reset = 1'b0; exp_fflags = '0;
    mds_done = 1'b1; mds_out = 32'h4120_0000; invalid = 1'b1;
    @(negedge clk);
    mds_done = 1'b0; invalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut_all !== '0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL late_done got %h ready=%b expected 0 ready=1", dut_all, req_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fflags_clr();
    run_op(2'd0, 3'd0, 32'h3F80_0000, 32'h3F80_0001, 1, 32'h3F80_0001, 5'b00001, 0, 1'b0, "ff_accrue");
    run_op(2'd1, 3'd0, 32'h3F80_0000, 32'h0000_0000, 2, 32'h7F80_0000, 5'b01000, 2, 1'b1, "ff_clr_hs");
    @(negedge clk); fflags_clr = 1'b1;
    @(negedge clk); fflags_clr = 1'b0;
    exp_fflags = '0;
    n_checks++;
    if (fflags !== exp_fflags) begin n_fail++; $display("FAIL ff_clr_idle got %b expected %b", fflags, exp_fflags); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom_range(0, 3)), 3'($urandom), pick_operand(), pick_operand(),
             $urandom_range(0, 12), $urandom, 5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, "random");
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    mds_out = '0; mds_done = 1'b0; overflow = 1'b0; underflow = 1'b0; invalid = 1'b0;
    inexact = 1'b0; div_by_zero = 1'b0; rsp_ready = 1'b0; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_fflags_clr();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
